ela_mem_arb: RTL

ELA_MEM_ARB -- requirements
Module: ela_mem_arb

---
 rtl/ela_mem_arb.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ela_mem_arb.sv
// ela_mem_arb
// -----------------------------------------------------------------------------
// Arbitrates one single-port 8192x8 SRAM between the ELA capture engine
// (writes) and the host (reads). A frame runs from a start pulse through
// FRAME_WORDS engine writes. After the last write the block waits until any
// host read in flight has returned, then reports done.
//
// At most one requester is granted per cycle. The grant is combinational from
// the requests and the current state. The memory strobes are registered, so
// the SRAM sees the access in the cycle after the grant. mem_rdata is sampled
// on the edge that closes that strobe cycle. Host read data therefore appears
// on host_rdata/host_rvalid two cycles after host_gnt. A new grant can be
// issued every cycle, and reads are pipelined.
//
// Build option:
//   ELA_ARB_HOST_PRIO_EN  defined   -> host wins every conflict with the engine.
//                         undefined -> round-robin. The requester that was not
//                                      granted most recently wins. Out of
//                                      reset, the engine is favoured.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start                    one-cycle pulse that begins a frame (IDLE/DONE only)
//   eng_req/addr/wdata       engine write request (considered in RUN only)
//   eng_gnt                  engine write accepted this cycle
//   host_req/addr            host read request (considered in every state)
//   host_gnt                 host read accepted this cycle
//   host_rvalid/rdata        read data, 2 cycles after host_gnt, for one cycle
//   mem_cen/wen/addr/wdata   registered SRAM strobes
//   mem_rdata                SRAM read data
//   busy                     frame in progress (RUN or DRAIN)
//   done                     frame complete (DONE), held until start or reset
// -----------------------------------------------------------------------------
module ela_mem_arb #(
  parameter int FRAME_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        eng_req,
  input  logic [12:0] eng_addr,
  input  logic [7:0]  eng_wdata,
  output logic        eng_gnt,
  input  logic        host_req,
  input  logic [12:0] host_addr,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [7:0]  host_rdata,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [13:0] LAST_CNT = 14'(FRAME_WORDS - 1);

  state_t      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic        eng_elig, host_elig;
  logic        eng_win, host_win;
  logic        rd_inflight;

  // Read pipeline. Bit 0: strobe cycle of a granted read. Bit 1: data cycle.
  logic [1:0]  rd_pipe_q;
  logic [7:0]  host_rdata_q;

  logic        mem_cen_q, mem_wen_q;
  logic [12:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

`ifndef ELA_ARB_HOST_PRIO_EN
  // Set when the host won the last grant. Reset to 1 so the engine wins the
  // first conflict.
  logic        last_host_q, last_host_d;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // The engine is eligible only in RUN. The counter cannot pass
    // FRAME_WORDS, because RUN is left on the final grant.
    eng_elig  = (state_q == RUN) && eng_req;
    host_elig = host_req;
`ifdef ELA_ARB_HOST_PRIO_EN
    host_win  = host_elig;
    eng_win   = eng_elig && !host_elig;
`else
    host_win  = host_elig && (!eng_elig || !last_host_q);
    eng_win   = eng_elig  && (!host_elig || last_host_q);
`endif
  end

  assign eng_gnt  = eng_win;
  assign host_gnt = host_win;

`ifndef ELA_ARB_HOST_PRIO_EN
  always_comb begin
    last_host_d = last_host_q;
    if (host_win)     last_host_d = 1'b1;
    else if (eng_win) last_host_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_host_q <= 1'b1;
    else     last_host_q <= last_host_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM and write counter
  // ---------------------------------------------------------------------------
  // A read still owes its data once it has been granted. That covers a grant
  // in this cycle and one granted last cycle. In both cases host_rvalid is
  // still ahead.
  assign rd_inflight = host_win || rd_pipe_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (eng_win) cnt_d = cnt_q + 14'd1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (eng_win && (cnt_q == LAST_CNT)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_inflight) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Registered SRAM strobes
  // ---------------------------------------------------------------------------
  // The address and write data hold their values in idle cycles. Only the
  // enables drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cen_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_cen_q <= eng_win || host_win;
      mem_wen_q <= eng_win;
      if (eng_win) begin
        mem_addr_q  <= eng_addr;
        mem_wdata_q <= eng_wdata;
      end else if (host_win) begin
        mem_addr_q  <= host_addr;
      end
    end
  end

  assign mem_cen   = mem_cen_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // ---------------------------------------------------------------------------
  // Host read return
  // ---------------------------------------------------------------------------
  // Reset flushes the pipe. A read caught by a mid-frame reset never returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      rd_pipe_q <= {rd_pipe_q[0], host_win};
      if (rd_pipe_q[0]) host_rdata_q <= mem_rdata;
    end
  end

  assign host_rvalid = rd_pipe_q[1];
  assign host_rdata  = host_rdata_q;

endmodule
